logic_table_sweeper: RTL and testbench

- Parametrised successor to the two-input gate/expression comparison exercises. Holds two implementations of a selectable W-bit bitwise logic function: a gate-primitive form and a continuous-assignment form.
- A sequential engine sweeps the full truth table of operands (a, b), compares both forms every cycle, counts mismatches and captures the first failing vector.
- Serves as a self-checking truth-table generator for the gate-level lab modules.

---
 rtl/logic_sweep_pkg.sv | 21 ++
 rtl/logic_gate_unit.sv | 45 ++++
 rtl/logic_table_sweeper.sv | 149 ++++++++++++++
 tb/tb_logic_table_sweeper.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared encodings for the logic table sweeper: function select codes and FSM states.
package logic_sweep_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANB  = 3'd6,
    OP_NAXB = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_gate_unit.sv
// Gate-primitive implementation of the W-bit bitwise logic function, one primitive set per bit.
module logic_gate_unit
  import logic_sweep_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic g_and, g_or, g_nand, g_nor, g_xor, g_xnor, g_na, g_anb, g_naxb;
    logic sel;

    and  u_and  (g_and,  a_i[i], b_i[i]);
    or   u_or   (g_or,   a_i[i], b_i[i]);
    nand u_nand (g_nand, a_i[i], b_i[i]);
    nor  u_nor  (g_nor,  a_i[i], b_i[i]);
    xor  u_xor  (g_xor,  a_i[i], b_i[i]);
    xnor u_xnor (g_xnor, a_i[i], b_i[i]);
    not  u_na   (g_na,   a_i[i]);
    and  u_anb  (g_anb,  g_na,   b_i[i]);
    xor  u_naxb (g_naxb, g_na,   b_i[i]);

    always_comb begin
      sel = g_and;
      case (op_i)
        OP_AND:  sel = g_and;
        OP_OR:   sel = g_or;
        OP_NAND: sel = g_nand;
        OP_NOR:  sel = g_nor;
        OP_XOR:  sel = g_xor;
        OP_XNOR: sel = g_xnor;
        OP_ANB:  sel = g_anb;
        OP_NAXB: sel = g_naxb;
        default: sel = g_and;
      endcase
    end

    assign s_o[i] = sel;
  end

endmodule

// File: rtl/logic_table_sweeper.sv
// Sweeps every (a, b) operand pair, compares the gate and expression forms of the selected
// function, counts mismatches and captures the first failing vector.
module logic_table_sweeper
  import logic_sweep_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic           inj_en,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic [W-1:0]   s_gate,
  output logic [W-1:0]   s_expr,
  output logic           mismatch,
  output logic [2*W:0]   err_count,
  output logic           first_err_valid,
  output logic [W-1:0]   first_err_a,
  output logic [W-1:0]   first_err_b
);

  localparam int VW = 2 * W;
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [VW-1:0] VEC_ONE  = VW'(1);
  localparam logic [VW:0]   ERR_ONE  = (VW + 1)'(1);

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [2:0]      op_q, op_d;
  logic            inj_q, inj_d;
  logic [VW:0]     err_q, err_d;
  logic            fev_q, fev_d;
  logic [W-1:0]    fea_q, fea_d;
  logic [W-1:0]    feb_q, feb_d;

  logic [W-1:0]    gate_raw;
  logic [W-1:0]    inj_mask;
  logic [W-1:0]    expr;

  assign a_out = vec_q[VW-1:W];
  assign b_out = vec_q[W-1:0];

  logic_gate_unit #(.W(W)) u_gate (
    .op_i (op_q),
    .a_i  (a_out),
    .b_i  (b_out),
    .s_o  (gate_raw)
  );

  // Fault injection only ever touches bit 0, and only on vectors where a[0] is set.
  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = inj_q & a_out[0];
  end

  assign s_gate = gate_raw ^ inj_mask;

  always_comb begin
    expr = '0;
    case (op_q)
      OP_AND:  expr = a_out & b_out;
      OP_OR:   expr = a_out | b_out;
      OP_NAND: expr = ~(a_out & b_out);
      OP_NOR:  expr = ~(a_out | b_out);
      OP_XOR:  expr = a_out ^ b_out;
      OP_XNOR: expr = ~(a_out ^ b_out);
      OP_ANB:  expr = ~a_out & b_out;
      OP_NAXB: expr = ~a_out ^ b_out;
      default: expr = '0;
    endcase
  end

  assign s_expr          = expr;
  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign mismatch        = busy && (s_gate != s_expr);
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_a     = fea_q;
  assign first_err_b     = feb_q;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    op_d    = op_q;
    inj_d   = inj_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          inj_d   = inj_en;
          vec_d   = '0;
          err_d   = '0;
          fev_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = a_out;
            feb_d = b_out;
          end
        end
        // Hold the last vector through DONE so the final operands stay visible.
        if (vec_q == VEC_LAST) begin
          state_d = S_DONE;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      op_q    <= '0;
      inj_q   <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
      feb_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      op_q    <= op_d;
      inj_q   <= inj_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
    end
  end

endmodule

// File: tb/tb_logic_table_sweeper.sv
// Directed bench for logic_table_sweeper: a W=2 instance for most scenarios plus a W=1 instance.
module tb_logic_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, inj_en;
  logic [2:0] op;
  logic       busy, done, mismatch, fev;
  logic [1:0] a_out, b_out, s_gate, s_expr, fea, feb;
  logic [4:0] err;

  logic       start1, inj1;
  logic [2:0] op1;
  logic       busy1, done1, mismatch1, fev1;
  logic [0:0] a1, b1, sg1, se1, fea1, feb1;
  logic [2:0] err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_table_sweeper #(.W(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .inj_en(inj_en),
    .busy(busy), .done(done), .a_out(a_out), .b_out(b_out),
    .s_gate(s_gate), .s_expr(s_expr), .mismatch(mismatch), .err_count(err),
    .first_err_valid(fev), .first_err_a(fea), .first_err_b(feb)
  );

  logic_table_sweeper #(.W(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .inj_en(inj1),
    .busy(busy1), .done(done1), .a_out(a1), .b_out(b1),
    .s_gate(sg1), .s_expr(se1), .mismatch(mismatch1), .err_count(err1),
    .first_err_valid(fev1), .first_err_a(fea1), .first_err_b(feb1)
  );

  // Reference truth table for the 2-bit operand case.
  function automatic logic [1:0] fmodel(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b);
    case (o)
      3'd0: fmodel = a & b;
      3'd1: fmodel = a | b;
      3'd2: fmodel = ~(a & b);
      3'd3: fmodel = ~(a | b);
      3'd4: fmodel = a ^ b;
      3'd5: fmodel = ~(a ^ b);
      3'd6: fmodel = ~a & b;
      default: fmodel = ~a ^ b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] o, input logic inj);
    start = 1'b1; op = o; inj_en = inj;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 1;
    while (done !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; inj_en = 1'b0;
    start1 = 1'b0; op1 = 3'd0; inj1 = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%0b exp=0", busy); failures++; end
    checks++; if (done !== 1'b0) begin $display("FAIL reset_done got=%0b exp=0", done); failures++; end
    checks++; if ({a_out, b_out} !== 4'h0) begin $display("FAIL reset_vec got=%0h exp=0", {a_out, b_out}); failures++; end
    checks++; if (err !== 5'd0) begin $display("FAIL reset_err got=%0d exp=0", err); failures++; end
    checks++; if ({fev, fea, feb} !== 5'd0) begin $display("FAIL reset_first got=%0h exp=0", {fev, fea, feb}); failures++; end
    checks++; if (mismatch !== 1'b0 || s_gate !== 2'd0) begin $display("FAIL reset_sgate got=%0b/%0h exp=0/0", mismatch, s_gate); failures++; end
    checks++; if (busy1 !== 1'b0 || err1 !== 3'd0) begin $display("FAIL reset_w1 got=%0b/%0d exp=0/0", busy1, err1); failures++; end
  endtask

  task automatic test_xnor_clean();
    launch(3'd5, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++; if (busy !== 1'b1) begin $display("FAIL xnor_busy k=%0d got=%0b exp=1", k, busy); failures++; end
      checks++; if ({a_out, b_out} !== 4'(k)) begin $display("FAIL xnor_vec got=%0h exp=%0h", {a_out, b_out}, k); failures++; end
      checks++; if (s_expr !== fmodel(3'd5, a_out, b_out) || mismatch !== 1'b0) begin
        $display("FAIL xnor_value k=%0d got=%0h/%0b exp=%0h/0", k, s_expr, mismatch, fmodel(3'd5, a_out, b_out)); failures++; end
      step();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL xnor_done got=%0b/%0b exp=1/0", done, busy); failures++; end
    checks++; if (err !== 5'd0 || fev !== 1'b0) begin $display("FAIL xnor_err got=%0d/%0b exp=0/0", err, fev); failures++; end
    step();
    checks++; if (done !== 1'b0) begin $display("FAIL xnor_done_pulse got=%0b exp=0", done); failures++; end
  endtask

  task automatic test_anb_inject();
    int cnt;
    launch(3'd6, 1'b1);
    wait_done(cnt);
    checks++; if (cnt != 17) begin $display("FAIL anb_latency got=%0d exp=17", cnt); failures++; end
    checks++; if (err !== 5'd8) begin $display("FAIL anb_err got=%0d exp=8", err); failures++; end
    checks++; if ({fev, fea, feb} !== {1'b1, 2'd1, 2'd0}) begin
      $display("FAIL anb_first got=%0b/%0d/%0d exp=1/1/0", fev, fea, feb); failures++; end
    step();
  endtask

  task automatic test_all_ops();
    int cnt;
    for (int o = 0; o < 8; o++) begin
      launch(3'(o), 1'b0);
      for (int k = 0; k < 16; k++) begin
        checks++; if (s_gate !== fmodel(3'(o), a_out, b_out) || s_expr !== fmodel(3'(o), a_out, b_out)) begin
          $display("FAIL ops_value op=%0d a=%0d b=%0d got=%0h/%0h exp=%0h", o, a_out, b_out, s_gate, s_expr, fmodel(3'(o), a_out, b_out)); failures++; end
        if (o == 0 && k == 13) begin
          checks++; if (s_gate !== 2'd1) begin $display("FAIL ops_and_3_1 got=%0d exp=1", s_gate); failures++; end
        end
        if (o == 7 && k == 0) begin
          checks++; if (s_gate !== 2'd3) begin $display("FAIL ops_naxb_0_0 got=%0d exp=3", s_gate); failures++; end
        end
        step();
      end
      wait_done(cnt);
      checks++; if (done !== 1'b1 || err !== 5'd0) begin $display("FAIL ops_err op=%0d got=%0b/%0d exp=1/0", o, done, err); failures++; end
      step();
    end
  endtask

  task automatic test_abort();
    int cnt;
    int dones = 0;
    launch(3'd4, 1'b1);
    for (int k = 0; k < 4; k++) step();
    checks++; if (busy !== 1'b1 || {a_out, b_out} !== 4'h4) begin
      $display("FAIL abort_pre got=%0b/%0h exp=1/4", busy, {a_out, b_out}); failures++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || {a_out, b_out} !== 4'h0) begin
      $display("FAIL abort_idle got=%0b/%0b/%0h exp=0/0/0", busy, done, {a_out, b_out}); failures++; end
    checks++; if (err !== 5'd0 || {fev, fea, feb} !== 5'd0) begin
      $display("FAIL abort_results got=%0d/%0h exp=0/0", err, {fev, fea, feb}); failures++; end
    for (int k = 0; k < 25; k++) begin
      if (done === 1'b1 || busy === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin $display("FAIL abort_no_done got=%0d exp=0", dones); failures++; end
    launch(3'd4, 1'b1);
    wait_done(cnt);
    checks++; if (cnt != 17 || err !== 5'd8) begin $display("FAIL abort_restart got=%0d/%0d exp=17/8", cnt, err); failures++; end
    step();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int busys = 0;
    launch(3'd4, 1'b1);
    start = 1'b1; op = 3'd0; inj_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1) busys++;
      if (done === 1'b1) begin
        dones++;
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checks++; if (dones != 1) begin $display("FAIL b2b_done_count got=%0d exp=1", dones); failures++; end
    checks++; if (busys != 16) begin $display("FAIL b2b_busy_cycles got=%0d exp=16", busys); failures++; end
    checks++; if (err !== 5'd8 || {fev, fea, feb} !== {1'b1, 2'd1, 2'd0}) begin
      $display("FAIL b2b_results got=%0d/%0b/%0d/%0d exp=8/1/1/0", err, fev, fea, feb); failures++; end
  endtask

  task automatic test_w1_nor();
    int cnt;
    start1 = 1'b1; op1 = 3'd3; inj1 = 1'b1;
    step();
    start1 = 1'b0;
    cnt = 1;
    while (done1 !== 1'b1 && cnt < 50) begin
      step();
      cnt++;
    end
    checks++; if (cnt != 5) begin $display("FAIL w1_latency got=%0d exp=5", cnt); failures++; end
    checks++; if (err1 !== 3'd2) begin $display("FAIL w1_err got=%0d exp=2", err1); failures++; end
    checks++; if ({fev1, fea1, feb1} !== 3'b110) begin
      $display("FAIL w1_first got=%0b/%0b/%0b exp=1/1/0", fev1, fea1, feb1); failures++; end
    step();
  endtask

  initial begin
    test_reset();
    test_xnor_clean();
    test_anb_inject();
    test_all_ops();
    test_abort();
    test_back_to_back();
    test_w1_nor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
